// File: rtl/rps_requester.sv
// Requester side of the 4-way rotating-priority grant interface.
// Holds one job per client as a remaining-beat counter, raises req while
// beats remain, consumes one beat per legal one-hot grant, and reports
// beats, completions, illegal grants and starvation.
module rps_requester #(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [1:0]       job_client,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic [3:0]       req,
  output logic             en,
  input  logic [3:0]       gnt,
  output logic             beat_valid,
  output logic [1:0]       beat_client,
  output logic [3:0]       done,
  output logic             proto_err,
  output logic [3:0]       starve,
  output logic [15:0]      beat_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [3:0][LEN_W-1:0]  rem;
  logic [3:0][WAIT_W-1:0] wait_cnt;
  logic                   gnt_onehot;
  logic                   legal;
  logic                   illegal;
  logic [1:0]             gnt_idx;
  logic                   accept;
  logic [3:0]             done_nxt;

  // Requests come straight from the counters, so they are register-timed.
  always_comb begin
    for (int i = 0; i < 4; i++) req[i] = (rem[i] != '0);
    en = |req;
  end

  // Grant qualification: exactly one bit set, and it lands on a requester.
  always_comb begin
    gnt_onehot = (gnt != 4'b0) && ((gnt & (gnt - 4'd1)) == 4'b0);
    legal      = gnt_onehot && ((gnt & req) != 4'b0);
    illegal    = (gnt != 4'b0) && !legal;
    gnt_idx    = 2'd0;
    for (int i = 0; i < 4; i++) if (gnt[i]) gnt_idx = 2'(i);
  end

  // A client takes a new job only once its previous one is fully drained.
  always_comb begin
    job_ready = (rem[job_client] == '0);
    accept    = job_valid && job_ready;
  end

  // Completion pulses: last beat granted, or a zero-length job accepted.
  always_comb begin
    done_nxt = 4'b0;
    if (legal && rem[gnt_idx] == LEN_W'(1)) done_nxt[gnt_idx] = 1'b1;
    if (accept && job_len == '0) done_nxt[job_client] = 1'b1;
  end

  // Beat bookkeeping; accept and grant never target the same client, since
  // accept needs rem==0 and a legal grant needs rem!=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem         <= '0;
      beat_valid  <= 1'b0;
      beat_client <= 2'd0;
      done        <= 4'b0;
      proto_err   <= 1'b0;
      beat_count  <= 16'd0;
    end else begin
      done       <= done_nxt;
      beat_valid <= legal;
      if (legal) begin
        rem[gnt_idx] <= rem[gnt_idx] - LEN_W'(1);
        beat_client  <= gnt_idx;
        beat_count   <= beat_count + 16'd1;
      end
      if (illegal) proto_err <= 1'b1;
      if (accept) rem[job_client] <= job_len;
    end
  end

  // Starvation: count consecutive ungranted request cycles, flag at the cap.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      starve   <= 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wait_cnt[i] == WAIT_W'(MAX_WAIT)) starve[i] <= 1'b1;
        if (!req[i] || (legal && gnt[i]))
          wait_cnt[i] <= '0;
        else if (!gnt[i] && wait_cnt[i] != WAIT_W'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rps_requester.sv
// Bench for rps_requester: directed scenarios followed by randomized jobs
// and grants, all checked every cycle against a per-client job model.
module tb_rps_requester;
  localparam int LEN_W = 4;
  localparam int MAX_WAIT = 8;

  logic clock = 0, reset = 1;
  logic job_valid = 0;
  logic [1:0] job_client = 0;
  logic [LEN_W-1:0] job_len = 0;
  logic job_ready;
  logic [3:0] req, gnt = 0, done, starve;
  logic en, beat_valid, proto_err;
  logic [1:0] beat_client;
  logic [15:0] beat_count;

  rps_requester #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .job_valid(job_valid), .job_client(job_client),
    .job_len(job_len), .job_ready(job_ready), .req(req), .en(en), .gnt(gnt),
    .beat_valid(beat_valid), .beat_client(beat_client), .done(done),
    .proto_err(proto_err), .starve(starve), .beat_count(beat_count));

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  // Reference: beats left per client, consecutive-wait count per client.
  int m_rem[4], m_wait[4];
  int m_cnt, m_bc;
  bit m_bv, m_pe;
  bit [3:0] m_done, m_starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [3:0] m_req();
    bit [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_rem[i] != 0);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_rem[i] = 0; m_wait[i] = 0; end
    m_cnt = 0; m_bc = 0; m_bv = 0; m_pe = 0; m_done = 0; m_starve = 0;
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic m_step();
    bit [3:0] r = m_req();
    bit legal;
    int gi;
    bit rdy;
    if (reset) begin m_reset(); return; end
    legal = ($countones(gnt) == 1) && ((gnt & r) != 0);
    rdy = (m_rem[job_client] == 0);
    m_done = 0;
    m_bv = legal;
    if (gnt != 0 && !legal) m_pe = 1;
    for (int i = 0; i < 4; i++) begin
      if (m_wait[i] == MAX_WAIT) m_starve[i] = 1;
      if (!r[i] || (legal && gnt[i])) m_wait[i] = 0;
      else if (!gnt[i] && m_wait[i] < MAX_WAIT) m_wait[i]++;
    end
    if (legal) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
      m_rem[gi]--;
      m_bc = gi;
      m_cnt = (m_cnt + 1) % 65536;
      if (m_rem[gi] == 0) m_done[gi] = 1;
    end
    if (job_valid && rdy) begin
      m_rem[job_client] = job_len;
      if (job_len == 0) m_done[job_client] = 1;
    end
  endtask

  // Apply inputs, check job_ready before the edge, clock, check outputs.
  task automatic cyc(input bit jv, input int jc, input int jl, input logic [3:0] g);
    job_valid = jv; job_client = 2'(jc); job_len = LEN_W'(jl); gnt = g;
    #1;
    if (!reset) chk("job_ready", job_ready, m_rem[jc] == 0);
    @(posedge clock);
    m_step();
    #1;
    chk("req", req, m_req());
    chk("en", en, m_req() != 0);
    chk("beat_valid", beat_valid, m_bv);
    chk("beat_client", beat_client, m_bc);
    chk("done", done, m_done);
    chk("proto_err", proto_err, m_pe);
    chk("starve", starve, m_starve);
    chk("beat_count", beat_count, m_cnt);
    job_valid = 0; gnt = 0;
  endtask

  int idx[$];
  int sel, k;
  bit [3:0] r;
  logic [3:0] g;

  initial begin
    m_reset();
    reset = 1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    reset = 0;
    cyc(0, 0, 0, 0);
    // Single job, three grants
    cyc(1, 2, 3, 0);
    repeat (3) cyc(0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 0);
    chk("beats3", beat_count, 16'd3);
    // Two jobs, alternating grants; busy client stalls
    cyc(1, 0, 2, 0);
    cyc(1, 1, 2, 0);
    cyc(1, 0, 7, 4'b0001);
    chk("busy_stall", dut.rem[0], 4'd1);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0);
    // Zero-length job
    cyc(1, 3, 0, 0);
    chk("zero_len_done", done, 4'b1000);
    cyc(0, 0, 0, 0);
    // Illegal grants
    cyc(1, 0, 2, 0);
    cyc(1, 1, 2, 0);
    cyc(0, 0, 0, 4'b0011);
    cyc(0, 0, 0, 4'b0100);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0010);
    // Starvation on client 1
    cyc(1, 1, 3, 0);
    repeat (10) cyc(0, 0, 0, 0);
    chk("starve1", starve[1], 1'b1);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 0, 0, 0);
    chk("starve_sticky", starve[1], 1'b1);
    // Reset mid-job
    cyc(1, 0, 5, 0);
    cyc(0, 0, 0, 4'b0001);
    reset = 1;
    cyc(0, 0, 0, 0);
    reset = 0;
    cyc(0, 0, 0, 0);
    chk("rst_req", req, 4'b0);
    chk("rst_cnt", beat_count, 16'd0);
    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      r = m_req();
      sel = $urandom_range(0, 99);
      g = 0;
      if (sel < 65) begin
        idx.delete();
        for (int i = 0; i < 4; i++) if (r[i]) idx.push_back(i);
        if (idx.size() > 0) begin
          k = idx[$urandom_range(0, idx.size() - 1)];
          g[k] = 1'b1;
        end
      end else if (sel < 67) begin
        g = 4'($urandom_range(1, 15));
      end
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 5), g);
    end
    reset = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
